hvac_zone_ctrl: RTL and testbench
=================================

HVAC_ZONE_CTRL -- requirements
Module: hvac_zone_ctrl

Interface
REQ-001 Parameter N_ZONES, default 4: number of independent climate zones, 1..16.
REQ-002 Parameter TEMP_W, default 5: temperature width in bits, unsigned.
REQ-003 Parameter HYST, default 2: hysteresis band in LSBs, 1..(2**TEMP_W)-1.
REQ-004 Parameter MIN_ON, default 4: minimum clock cycles a zone remains in HEAT or COOL; 0 disables the dwell.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port enable, input, 1: global enable; low forces all zones to IDLE.
REQ-008 Port mode, input, 2: 00 off, 01 heat-only, 10 cool-only, 11 auto; common to all zones.
REQ-009 Port temperature, input, N_ZONES*TEMP_W: packed measured temperatures; zone i occupies bits [i*TEMP_W +: TEMP_W].
REQ-010 Port desired_temp, input, N_ZONES*TEMP_W: packed set-points, same packing as temperature.
REQ-011 Port heating, output, N_ZONES: bit i high while zone i is in HEAT.
REQ-012 Port cooling, output, N_ZONES: bit i high while zone i is in COOL.

Function
REQ-013 Each zone SHALL run an independent FSM with states IDLE, HEAT and COOL, together with a dwell counter.
REQ-014 Thresholds: lo = desired-HYST, saturating at 0; hi = desired+HYST, saturating at 2**TEMP_W-1; neither SHALL wrap.
REQ-015 heat_ok = enable & mode[0]; cool_ok = enable & mode[1].
REQ-016 IDLE->HEAT when heat_ok and temp <= lo; IDLE->COOL when cool_ok and temp >= hi; when both conditions hold, HEAT wins.
REQ-017 HEAT->IDLE when temp >= desired and the dwell count is >= MIN_ON, or immediately when heat_ok is low, ignoring the dwell.
REQ-018 COOL->IDLE when temp <= desired and the dwell count is >= MIN_ON, or immediately when cool_ok is low, ignoring the dwell.
REQ-019 HEAT and COOL SHALL never be adjacent; every reversal passes through at least one IDLE cycle.
REQ-020 The dwell counter SHALL clear on entry to HEAT or COOL, increment each cycle in that state, and saturate at MIN_ON.
REQ-021 The dwell counter width SHALL be max(1, clog2(MIN_ON+1)).
REQ-022 heating and cooling SHALL be registered state decodes: an input change is reflected on the outputs one rising edge later.
REQ-023 heating[i] & cooling[i] SHALL never be 1 in any cycle.
REQ-024 Inputs SHALL be sampled only on rising clock edges; combinational glitches between edges have no effect.

Reset
REQ-025 While rst_n is low, every zone SHALL be in IDLE, every dwell counter SHALL be 0, and heating and cooling SHALL be all-zero, without waiting for a clock edge.
REQ-026 Reset asserted mid-HEAT or mid-COOL SHALL drop the affected outputs asynchronously.
REQ-027 After rst_n deasserts, the first transition SHALL be evaluated on the first subsequent rising edge.

Structure
REQ-028 Package hvac_pkg SHALL hold the zone state encoding (IDLE, HEAT, COOL) and the mode constants (MODE_OFF, MODE_HEAT, MODE_COOL, MODE_AUTO).
REQ-029 Sub-module hvac_zone SHALL implement one zone FSM with its dwell counter and threshold arithmetic; hvac_zone_ctrl SHALL instantiate it N_ZONES times in a generate loop and perform only the bus slicing.

Verification
(All scenarios use N_ZONES=2, TEMP_W=5, HYST=2, MIN_ON=4, mode=11, enable=1 unless stated.)
REQ-030 Dwell: zone0 desired=20, temp=18 -> heating[0]=1 after the next edge; temp=21 one cycle later -> heating[0] stays 1 until 4 cycles in HEAT, then drops on the next edge.
REQ-031 Saturation: desired=1, temp=0 -> heating=1 (lo=0). desired=30, temp=31 -> cooling=1 (hi=31). desired=31, temp=31 -> both outputs stay 0.
REQ-032 Mode override: heating active with dwell=1 and mode switched to 10 while temp=25, desired=20 -> heating=0 after the next edge, IDLE for one cycle, cooling=1 one edge later.
REQ-033 Independence: zone0 temp=10 with desired=20, zone1 temp=28 with desired=20 -> heating=01 and cooling=10 concurrently; heating & cooling is always 0.
REQ-034 Reset: rst_n pulsed low between edges while both zones are active -> outputs read 00 before the next edge and stay 00 until one edge after release.
REQ-035 Enable: enable=0 with zone0 temp=10 and desired=20 -> heating and cooling remain 00 for 20 cycles.

Source files
------------

// File: rtl/hvac_pkg.sv
// Shared definitions for the zone climate controller: zone state encoding,
// mode constants and the dwell-counter width helper.
package hvac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b01,
    COOL = 2'b10
  } zone_state_t;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_HEAT = 2'b01;
  localparam logic [1:0] MODE_COOL = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  // The counter only has to reach MIN_ON; a zero dwell still needs one bit.
  function automatic int dwell_width(input int min_on);
    return (min_on < 1) ? 1 : $clog2(min_on + 1);
  endfunction

endpackage

// File: rtl/hvac_zone.sv
// One climate zone: IDLE/HEAT/COOL FSM with hysteresis thresholds and a
// minimum-dwell counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | neither heating nor cooling; reversals always pass here
// HEAT  | heating demanded; held for at least MIN_ON cycles
// COOL  | cooling demanded; held for at least MIN_ON cycles
module hvac_zone
  import hvac_pkg::*;
#(
  parameter int TEMP_W = 5,
  parameter int HYST   = 2,
  parameter int MIN_ON = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] temp,
  input  logic [TEMP_W-1:0] desired,
  output logic              heating,
  output logic              cooling
);

  localparam int CW = dwell_width(MIN_ON);
  localparam logic [CW-1:0]   DWELL_MAX = CW'(MIN_ON);
  localparam logic [TEMP_W:0] HYST_X    = (TEMP_W + 1)'(HYST);
  localparam logic [TEMP_W:0] TEMP_MAX  = {1'b0, {TEMP_W{1'b1}}};

  zone_state_t       state, state_nxt;
  logic [CW-1:0]     dwell, dwell_nxt;
  logic [TEMP_W:0]   desired_x, diff_x, sum_x;
  logic [TEMP_W-1:0] lo, hi;
  logic              heat_ok, cool_ok, want_heat, want_cool, dwell_done;

  // Thresholds are computed one bit wider so they clamp instead of wrapping.
  assign desired_x = {1'b0, desired};
  assign diff_x    = desired_x - HYST_X;
  assign sum_x     = desired_x + HYST_X;
  assign lo        = (desired_x >= HYST_X) ? diff_x[TEMP_W-1:0] : '0;
  assign hi        = (sum_x > TEMP_MAX) ? '1 : sum_x[TEMP_W-1:0];

  assign heat_ok = enable & mode[0];
  assign cool_ok = enable & mode[1];

  // At the rails a clamped threshold can land on the set-point itself; a zone
  // sitting exactly at its set-point never calls for heat or cool.
  assign want_heat  = heat_ok && (temp <= lo) && (temp < desired);
  assign want_cool  = cool_ok && (temp >= hi) && (temp > desired);
  assign dwell_done = (dwell >= DWELL_MAX);

  // Next-state and dwell-counter update.
  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    case (state)
      IDLE: begin
        if (want_heat) begin
          state_nxt = HEAT;
          dwell_nxt = '0;
        end else if (want_cool) begin
          state_nxt = COOL;
          dwell_nxt = '0;
        end
      end
      HEAT: begin
        if (!heat_ok || ((temp >= desired) && dwell_done)) begin
          state_nxt = IDLE;
          dwell_nxt = '0;
        end else if (!dwell_done) begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      COOL: begin
        if (!cool_ok || ((temp <= desired) && dwell_done)) begin
          state_nxt = IDLE;
          dwell_nxt = '0;
        end else if (!dwell_done) begin
          dwell_nxt = dwell + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dwell_nxt = '0;
      end
    endcase
  end

  // State and dwell registers; reset clears them without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      dwell <= dwell_nxt;
    end
  end

  assign heating = (state == HEAT);
  assign cooling = (state == COOL);

endmodule

// File: rtl/hvac_zone_ctrl.sv
// Multi-zone HVAC controller: slices the packed temperature and set-point
// buses and runs one independent hvac_zone per zone.
module hvac_zone_ctrl
  import hvac_pkg::*;
#(
  parameter int N_ZONES = 4,
  parameter int TEMP_W  = 5,
  parameter int HYST    = 2,
  parameter int MIN_ON  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [N_ZONES*TEMP_W-1:0] temperature,
  input  logic [N_ZONES*TEMP_W-1:0] desired_temp,
  output logic [N_ZONES-1:0]        heating,
  output logic [N_ZONES-1:0]        cooling
);

  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    hvac_zone #(
      .TEMP_W (TEMP_W),
      .HYST   (HYST),
      .MIN_ON (MIN_ON)
    ) u_zone (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .mode    (mode),
      .temp    (temperature[i*TEMP_W +: TEMP_W]),
      .desired (desired_temp[i*TEMP_W +: TEMP_W]),
      .heating (heating[i]),
      .cooling (cooling[i])
    );
  end

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Bench for hvac_zone_ctrl: directed scenarios with literal expectations plus
// a cycle-by-cycle comparison against a behavioural zone model.
module tb_hvac_zone_ctrl;

  localparam int NZ   = 2;
  localparam int TW   = 5;
  localparam int HY   = 2;
  localparam int MO   = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic [1:0]      mode;
  logic [NZ*TW-1:0] temperature;
  logic [NZ*TW-1:0] desired_temp;
  logic [NZ-1:0]   heating;
  logic [NZ-1:0]   cooling;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 0;

  // Model: 0 idle, 1 heating, 2 cooling; cyc = cycles spent in current state.
  int m_st [NZ];
  int m_cyc[NZ];

  hvac_zone_ctrl #(
    .N_ZONES (NZ),
    .TEMP_W  (TW),
    .HYST    (HY),
    .MIN_ON  (MO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode         (mode),
    .temperature  (temperature),
    .desired_temp (desired_temp),
    .heating      (heating),
    .cooling      (cooling)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    for (int z = 0; z < NZ; z++) begin
      m_st[z]  = 0;
      m_cyc[z] = 0;
    end
  end

  // Behavioural model, advanced on each rising edge from the sampled inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < NZ; z++) begin
        m_st[z]  <= 0;
        m_cyc[z] <= 0;
      end
    end else begin
      for (int z = 0; z < NZ; z++) begin
        int t, d, lo, hi;
        bit hok, cok, held;
        t   = int'(temperature[z*TW +: TW]);
        d   = int'(desired_temp[z*TW +: TW]);
        lo  = (d - HY < 0) ? 0 : d - HY;
        hi  = (d + HY > TMAX) ? TMAX : d + HY;
        hok = enable && mode[0];
        cok = enable && mode[1];
        held = (m_cyc[z] >= MO);
        if (m_st[z] == 0) begin
          if (hok && t <= lo && t < d) begin
            m_st[z] <= 1; m_cyc[z] <= 0;
          end else if (cok && t >= hi && t > d) begin
            m_st[z] <= 2; m_cyc[z] <= 0;
          end
        end else if (m_st[z] == 1) begin
          if (!hok || (t >= d && held)) begin
            m_st[z] <= 0; m_cyc[z] <= 0;
          end else begin
            m_cyc[z] <= m_cyc[z] + 1;
          end
        end else begin
          if (!cok || (t <= d && held)) begin
            m_st[z] <= 0; m_cyc[z] <= 0;
          end else begin
            m_cyc[z] <= m_cyc[z] + 1;
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int z = 0; z < NZ; z++) begin
        n_vec++;
        if (heating[z] !== (m_st[z] == 1) || cooling[z] !== (m_st[z] == 2)) begin
          n_miss++;
          $display("FAIL model zone%0d @%0t: heating=%b cooling=%b, required heating=%b cooling=%b",
                   z, $time, heating[z], cooling[z], m_st[z] == 1, m_st[z] == 2);
        end
      end
      n_vec++;
      if ((heating & cooling) !== '0) begin
        n_miss++;
        $display("FAIL exclusive @%0t: heating&cooling=%b, required 00", $time, heating & cooling);
      end
    end
  end

  task automatic chk(input string name, input logic [NZ-1:0] act, input logic [NZ-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %b, required %b", name, $time, act, exp);
    end
  endtask

  task automatic set_zone(input int z, input int t, input int d);
    temperature[z*TW +: TW]  = TW'(t);
    desired_temp[z*TW +: TW] = TW'(d);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 0;
    enable       = 1;
    mode         = 2'b11;
    temperature  = '0;
    desired_temp = '0;
    set_zone(0, 20, 20);
    set_zone(1, 20, 20);
    #2;
    chk("reset_heating", heating, 2'b00);
    chk("reset_cooling", cooling, 2'b00);
    step();
    rst_n  = 1;
    chk_on = 1;

    // Dwell: entry, hold through MIN_ON cycles, then release.
    set_zone(0, 18, 20);
    step();
    chk("dwell_entry", heating, 2'b01);
    set_zone(0, 21, 20);
    repeat (4) begin
      step();
      chk("dwell_hold", heating, 2'b01);
    end
    step();
    chk("dwell_exit", heating, 2'b00);

    // Threshold saturation at both rails.
    set_zone(0, 0, 1);
    step();
    chk("sat_lo_heat", heating, 2'b01);
    mode = 2'b00;
    step();
    chk("mode_off_drop", heating | cooling, 2'b00);
    mode = 2'b11;
    set_zone(0, 31, 30);
    step();
    chk("sat_hi_cool", cooling, 2'b01);
    mode = 2'b00;
    step();
    mode = 2'b11;
    set_zone(0, 31, 31);
    step();
    step();
    chk("sat_at_setpoint_h", heating, 2'b00);
    chk("sat_at_setpoint_c", cooling, 2'b00);

    // Mode override mid-HEAT: immediate drop, one IDLE cycle, then COOL.
    set_zone(0, 10, 20);
    step();
    chk("ovr_heat", heating, 2'b01);
    step();
    mode = 2'b10;
    set_zone(0, 25, 20);
    step();
    chk("ovr_idle", heating | cooling, 2'b00);
    step();
    chk("ovr_cool", cooling, 2'b01);

    // Independent zones.
    mode = 2'b00;
    step();
    mode = 2'b11;
    set_zone(0, 10, 20);
    set_zone(1, 28, 20);
    step();
    chk("indep_heat", heating, 2'b01);
    chk("indep_cool", cooling, 2'b10);
    repeat (3) step();

    // Asynchronous reset pulse between edges.
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_h", heating, 2'b00);
    chk("async_rst_c", cooling, 2'b00);
    #1 rst_n = 1;
    step();
    chk("post_rst_hold", heating | cooling, 2'b00);
    step();
    chk("post_rst_heat", heating, 2'b01);
    chk("post_rst_cool", cooling, 2'b10);

    // Global enable low keeps every zone idle.
    enable = 0;
    set_zone(0, 10, 20);
    step();
    repeat (20) begin
      step();
      chk("enable_low", heating | cooling, 2'b00);
    end

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
